param_dmem_responder: RTL and testbench
=======================================

# param_dmem_responder

Single-outstanding data-memory responder that serves the datapath's data-memory request/response port. It accepts a word request (read or write) over a val/rdy handshake and holds the captured request in a fixed-latency pipeline. It then returns a 32-bit response over a second val/rdy handshake. It sits beside the core in simulation and FPGA builds and owns the word-addressed data storage. It also has a backdoor init port for program and data loading.

## Interface
Parameters:
- P_ADDR_BITS, 8: log2 of the word count; storage holds 2^P_ADDR_BITS 32-bit words.
- P_LATENCY, 2: cycles from request acceptance to first response-valid cycle; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- dmemreq_val  in  1  request valid.
- dmemreq_rdy  out  1  responder can accept a request this cycle.
- dmemreq_msg_type  in  1  0 = read, 1 = write.
- dmemreq_msg_addr  in  32  byte address. Bits [1:0] are ignored. The word index is addr[P_ADDR_BITS+1:2]. Upper bits are ignored, so addresses wrap.
- dmemreq_msg_data  in  32  write data; ignored for reads.
- dmemresp_val  out  1  response valid.
- dmemresp_rdy  in  1  consumer accepts the response.
- dmemresp_msg_type  out  1  echo of the request type.
- dmemresp_msg_data  out  32  read data; 0 for writes.
- init_en  in  1  backdoor write enable.
- init_addr  in  P_ADDR_BITS  backdoor word index.
- init_data  in  32  backdoor write data.

## Operation
- There are three states: IDLE, WAIT and RESP.
- **IDLE**
  - dmemreq_rdy = !init_en; dmemresp_val = 0.
  - A request is accepted on an edge where dmemreq_val & dmemreq_rdy.
  - At that edge the block latches the type, and for a read it captures the addressed word into the response data register.
  - For a write, the same edge writes dmemreq_msg_data into storage and clears the response data register to 0.
  - The latency counter loads P_LATENCY-1.
  - Next state is RESP if P_LATENCY == 1, else WAIT.
- **WAIT**
  - dmemreq_rdy = 0; dmemresp_val = 0.
  - The counter decrements each cycle.
  - When the counter reaches 1, the next state is RESP.
- **RESP**
  - dmemreq_rdy = 0; dmemresp_val = 1.
  - The type and data outputs are held stable until the handshake.
  - On dmemresp_val & dmemresp_rdy the next state is IDLE.
  - A new request is never accepted in the same cycle as the response handshake.
- **Backdoor init port**
  - While init_en = 1, storage[init_addr] <= init_data every edge, in any state.
  - init_en forces dmemreq_rdy = 0, so a request write and a backdoor write never collide.
  - A backdoor write to the address of an in-flight read does not alter that read's already-captured data.
- **Read ordering**: a read accepted after a write response reads the new value, because writes commit at acceptance.
- **Reset**
  - State goes to IDLE and the counter to 0.
  - Response data and type registers go to 0.
  - Storage is not cleared; init_en writes are still honoured while reset is high.
- Reset mid-transaction (WAIT or RESP) abandons the response. A write already committed at acceptance stays committed.

## Timing
- Reset values, during the reset cycle and while reset is held:
  - dmemreq_rdy = 0.
  - dmemresp_val = 0.
  - dmemresp_msg_type = 0.
  - dmemresp_msg_data = 0.
- In the first cycle after reset deasserts, dmemreq_rdy = 1 if init_en = 0.
- Latency: a request accepted at the edge ending cycle k gives dmemresp_val = 1 in cycle k+P_LATENCY.
- Peak throughput with dmemresp_rdy tied high is one request per P_LATENCY+1 cycles.
- Back-pressure: dmemresp_val stays high with constant payload for as many cycles as dmemresp_rdy is low.
- dmemreq_rdy depends only on state and init_en, with no combinational path from dmemreq_val. dmemresp_val is a pure state decode.

## Test plan
- **Backdoor load, then read**
  - Stimulus: init_en writes 0xDEADBEEF to index 3; then a read to addr 0x0000000C with P_LATENCY=2 and resp_rdy=1.
  - Required: resp_val=1 exactly 2 cycles after the accept edge, data 0xDEADBEEF, type 0; rdy high again the following cycle.
- **Write then read, with address wrap**
  - Stimulus: write 0x12345678 to addr 0x00000404 (P_ADDR_BITS=8); then read addr 0x00000004.
  - Required: write response has type 1 and data 0; the read returns 0x12345678.
- **Response back-pressure**
  - Stimulus: read issued, resp_rdy held low 5 cycles after resp_val rises.
  - Required: resp_val and data are stable all 5 cycles, dmemreq_rdy stays 0, and IDLE is entered one cycle after resp_rdy rises.
- **Latency 1, streaming**
  - Stimulus: P_LATENCY=1, dmemreq_val and resp_rdy held high, 4 reads to indices 0..3.
  - Required: accepts occur in cycles 0, 2, 4, 6 and responses in cycles 1, 3, 5, 7, in order.
- **Init blocks requests**
  - Stimulus: init_en=1 while dmemreq_val=1 in IDLE for 3 cycles.
  - Required: dmemreq_rdy=0 for those 3 cycles, no accept occurs, and the accept happens in the first cycle after init_en drops.
- **Reset mid-operation**
  - Stimulus: write 0xA5A5A5A5 accepted, reset pulsed during WAIT, then a read of the same address.
  - Required: no response for the write; outputs are 0 during reset; the read returns 0xA5A5A5A5.

Source files
------------

// File: rtl/param_dmem_responder.sv
// param_dmem_responder
// Single-outstanding data-memory responder: accepts one word request over a
// val/rdy handshake, holds it for a fixed latency, then returns a response.
// Word-addressed storage with a backdoor init port for program/data loading.

module param_dmem_responder #(
  parameter int P_ADDR_BITS = 8,
  parameter int P_LATENCY   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   dmemreq_val,
  output logic                   dmemreq_rdy,
  input  logic                   dmemreq_msg_type,
  input  logic [31:0]            dmemreq_msg_addr,
  input  logic [31:0]            dmemreq_msg_data,
  output logic                   dmemresp_val,
  input  logic                   dmemresp_rdy,
  output logic                   dmemresp_msg_type,
  output logic [31:0]            dmemresp_msg_data,
  input  logic                   init_en,
  input  logic [P_ADDR_BITS-1:0] init_addr,
  input  logic [31:0]            init_data
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int NUM_WORDS = 1 << P_ADDR_BITS;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   type_q, type_d;
  logic [31:0]            data_q, data_d;
  logic [31:0]            mem [0:NUM_WORDS-1];

  logic [P_ADDR_BITS-1:0] reqIdx;
  logic [31:0]            rdWord;
  logic                   reqFire;
  logic                   unusedAddrBits;

  // Byte address to word index; low byte-offset bits and upper bits drop out,
  // so addresses wrap around the storage.
  assign reqIdx         = dmemreq_msg_addr[P_ADDR_BITS+1:2];
  assign unusedAddrBits = ^{dmemreq_msg_addr[31:P_ADDR_BITS+2], dmemreq_msg_addr[1:0]};
  assign rdWord         = mem[reqIdx];

  // Request side is ready only when idle and the backdoor is quiet, so a
  // request write and an init write can never land on the same edge.
  assign dmemreq_rdy = (state_q == IDLE) && !init_en && !reset;
  assign reqFire     = dmemreq_val && dmemreq_rdy;

  // Response outputs are forced to zero while reset is asserted, even in the
  // first reset cycle when the registers still hold stale values.
  assign dmemresp_val      = (state_q == RESP) && !reset;
  assign dmemresp_msg_type = type_q && !reset;
  assign dmemresp_msg_data = reset ? 32'd0 : data_q;

  // Next-state logic: capture at acceptance, count down, then hold until taken.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    type_d  = type_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (reqFire) begin
          type_d  = dmemreq_msg_type;
          data_d  = dmemreq_msg_type ? 32'd0 : rdWord;
          cnt_d   = 4'(P_LATENCY - 1);
          state_d = (P_LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (dmemresp_rdy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      type_q  <= 1'b0;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      type_q  <= type_d;
      data_q  <= data_d;
    end
  end

  // Storage: backdoor writes are honoured in any state, including reset;
  // request writes commit at acceptance so later reads see the new value.
  always_ff @(posedge clk) begin
    if (init_en) begin
      mem[init_addr] <= init_data;
    end else if (reqFire && dmemreq_msg_type) begin
      mem[reqIdx] <= dmemreq_msg_data;
    end
  end

endmodule

// File: tb/tb_param_dmem_responder.sv
// Testbench for param_dmem_responder: table-driven directed transactions,
// hand-written corner-case sequences, and randomized traffic against a
// transaction-level memory model.

module tb_param_dmem_responder;

  localparam int AB  = 8;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;

  // Main instance (latency 2)
  logic        reqVal, reqRdy, reqType;
  logic [31:0] reqAddr, reqData;
  logic        respVal, respRdy, respType;
  logic [31:0] respData;
  logic        initEn;
  logic [7:0]  initAddr;
  logic [31:0] initData;

  // Streaming instance (latency 1)
  logic        sReqVal, sReqRdy, sReqType;
  logic [31:0] sReqAddr, sReqData;
  logic        sRespVal, sRespRdy, sRespType;
  logic [31:0] sRespData;
  logic        sInitEn;
  logic [7:0]  sInitAddr;
  logic [31:0] sInitData;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] refMem [0:255];

  typedef struct {
    string       name;
    logic        t;
    logic [31:0] addr;
    logic [31:0] data;
    int          bp;
    logic        expT;
    logic [31:0] expD;
  } vec_t;

  vec_t vecs [7];

  param_dmem_responder #(.P_ADDR_BITS(AB), .P_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .dmemreq_val(reqVal), .dmemreq_rdy(reqRdy), .dmemreq_msg_type(reqType),
    .dmemreq_msg_addr(reqAddr), .dmemreq_msg_data(reqData),
    .dmemresp_val(respVal), .dmemresp_rdy(respRdy), .dmemresp_msg_type(respType),
    .dmemresp_msg_data(respData),
    .init_en(initEn), .init_addr(initAddr), .init_data(initData)
  );

  param_dmem_responder #(.P_ADDR_BITS(AB), .P_LATENCY(1)) dutStream (
    .clk(clk), .reset(reset),
    .dmemreq_val(sReqVal), .dmemreq_rdy(sReqRdy), .dmemreq_msg_type(sReqType),
    .dmemreq_msg_addr(sReqAddr), .dmemreq_msg_data(sReqData),
    .dmemresp_val(sRespVal), .dmemresp_rdy(sRespRdy), .dmemresp_msg_type(sRespType),
    .dmemresp_msg_data(sRespData),
    .init_en(sInitEn), .init_addr(sInitAddr), .init_data(sInitData)
  );

  // Free-running clock
  always #5 clk = ~clk;

  function automatic logic [7:0] wordIdx(input logic [31:0] a);
    return a[9:2];
  endfunction

  // Single comparison; every check in the bench goes through here
  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // One backdoor write cycle on the main instance, mirrored into the model
  task automatic initWrite(input logic [7:0] idx, input logic [31:0] d);
    initEn   = 1'b1;
    initAddr = idx;
    initData = d;
    @(negedge clk);
    initEn   = 1'b0;
    refMem[idx] = d;
  endtask

  // Full request/response transaction on the main instance, starting and
  // ending at a negedge with the DUT idle. Optionally back-pressures the
  // response and pokes the backdoor at the in-flight address.
  task automatic applyStimulus(input string name, input logic t, input logic [31:0] a,
                               input logic [31:0] d, input int bp, input logic poke,
                               input logic [31:0] pokeData, input logic expT,
                               input logic [31:0] expD);
    int   lat;
    logic pokeOn;
    pokeOn = 1'b0;
    #1;
    checkOutput({name, ".reqRdy"}, 32'(reqRdy), 32'd1);
    reqVal  = 1'b1;
    reqType = t;
    reqAddr = a;
    reqData = d;
    @(posedge clk);
    if (t) refMem[wordIdx(a)] = d;
    @(negedge clk);
    reqVal = 1'b0;
    if (poke) begin
      initEn   = 1'b1;
      initAddr = wordIdx(a);
      initData = pokeData;
      pokeOn   = 1'b1;
      refMem[wordIdx(a)] = pokeData;
    end
    lat = 1;
    while (!respVal && lat < 20) begin
      @(negedge clk);
      initEn = 1'b0;
      lat++;
    end
    if (!respVal) begin
      miscompares++;
      vectors++;
      $display("[TB] FAIL %s.timeout: no response within %0d cycles", name, lat);
      initEn = 1'b0;
      return;
    end
    checkOutput({name, ".latency"}, 32'(lat), 32'(LAT));
    checkOutput({name, ".respType"}, 32'(respType), 32'(expT));
    checkOutput({name, ".respData"}, respData, expD);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      initEn = 1'b0;
      checkOutput({name, ".bpVal"}, 32'(respVal), 32'd1);
      checkOutput({name, ".bpData"}, respData, expD);
      checkOutput({name, ".bpType"}, 32'(respType), 32'(expT));
      checkOutput({name, ".bpReqRdy"}, 32'(reqRdy), 32'd0);
    end
    respRdy = 1'b1;
    @(negedge clk);
    respRdy = 1'b0;
    initEn  = 1'b0;
    #1;
    checkOutput({name, ".idleVal"}, 32'(respVal), 32'd0);
    checkOutput({name, ".idleRdy"}, 32'(reqRdy), 32'd1);
    if (pokeOn) pokeOn = 1'b0;
  endtask

  int          accCyc [4];
  int          respCyc [4];
  logic [31:0] respDat [4];

  initial begin
    int          acc, nResp;
    logic        t, poke;
    logic [31:0] a, d, expD;

    reset = 1'b1;
    reqVal = 1'b0; reqType = 1'b0; reqAddr = '0; reqData = '0; respRdy = 1'b0;
    initEn = 1'b0; initAddr = '0; initData = '0;
    sReqVal = 1'b0; sReqType = 1'b0; sReqAddr = '0; sReqData = '0; sRespRdy = 1'b0;
    sInitEn = 1'b0; sInitAddr = '0; sInitData = '0;
    for (int i = 0; i < 256; i++) refMem[i] = 32'd0;

    // Reset phase: outputs must be zero, backdoor writes still land
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      initEn    = (i == 0);
      initAddr  = 8'd3;
      initData  = 32'hDEADBEEF;
      sInitEn   = 1'b1;
      sInitAddr = 8'(i);
      sInitData = 32'h1000 + 32'(i);
      #1;
      checkOutput("rst.reqRdy", 32'(reqRdy), 32'd0);
      checkOutput("rst.respVal", 32'(respVal), 32'd0);
      checkOutput("rst.respType", 32'(respType), 32'd0);
      checkOutput("rst.respData", respData, 32'd0);
      @(negedge clk);
    end
    initEn  = 1'b0;
    sInitEn = 1'b0;
    refMem[3] = 32'hDEADBEEF;
    reset = 1'b0;
    @(negedge clk);

    // Directed table
    vecs[0] = '{"bdRead",   1'b0, 32'h0000000C, 32'h0,          0, 1'b0, 32'hDEADBEEF};
    vecs[1] = '{"wrWrap",   1'b1, 32'h00000404, 32'h12345678,   0, 1'b1, 32'h0};
    vecs[2] = '{"rdWrap",   1'b0, 32'h00000004, 32'h0,          0, 1'b0, 32'h12345678};
    vecs[3] = '{"rdLowBit", 1'b0, 32'h00000007, 32'hFFFFFFFF,   1, 1'b0, 32'h12345678};
    vecs[4] = '{"wrBp",     1'b1, 32'h00000010, 32'hCAFEF00D,   2, 1'b1, 32'h0};
    vecs[5] = '{"rdBp5",    1'b0, 32'h00000010, 32'h0,          5, 1'b0, 32'hCAFEF00D};
    vecs[6] = '{"rdHiWrap", 1'b0, 32'hFFFFFC0C, 32'h0,          0, 1'b0, 32'hDEADBEEF};
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].name, vecs[i].t, vecs[i].addr, vecs[i].data, vecs[i].bp,
                    1'b0, 32'h0, vecs[i].expT, vecs[i].expD);
    end

    // Init blocks requests for three cycles, then the read is accepted
    reqVal = 1'b1; reqType = 1'b0; reqAddr = 32'h0000000C;
    initEn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      initAddr = 8'(40 + k);
      initData = $urandom;
      refMem[40 + k] = initData;
      #1;
      checkOutput("initBlk.reqRdy", 32'(reqRdy), 32'd0);
      checkOutput("initBlk.respVal", 32'(respVal), 32'd0);
      @(negedge clk);
    end
    initEn = 1'b0;
    applyStimulus("initBlk.read", 1'b0, 32'h0000000C, 32'h0, 0, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF);

    // Reset during WAIT abandons the write response but keeps the write
    #1;
    checkOutput("rstMid.reqRdy", 32'(reqRdy), 32'd1);
    reqVal = 1'b1; reqType = 1'b1; reqAddr = 32'h00000020; reqData = 32'hA5A5A5A5;
    @(posedge clk);
    refMem[8] = 32'hA5A5A5A5;
    @(negedge clk);
    reqVal = 1'b0;
    reset  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checkOutput("rstMid.respVal", 32'(respVal), 32'd0);
      checkOutput("rstMid.respType", 32'(respType), 32'd0);
      checkOutput("rstMid.respData", respData, 32'd0);
      checkOutput("rstMid.reqRdy", 32'(reqRdy), 32'd0);
      @(negedge clk);
    end
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("rstMid.noResp", 32'(respVal), 32'd0);
    end
    applyStimulus("rstMid.read", 1'b0, 32'h00000020, 32'h0, 0, 1'b0, 32'h0, 1'b0, 32'hA5A5A5A5);

    // Latency-1 streaming: val and resp_rdy held high, four reads
    acc = 0; nResp = 0;
    sRespRdy = 1'b1;
    for (int c = 0; c < 10; c++) begin
      sReqVal  = (acc < 4);
      sReqAddr = 32'(acc) * 4;
      #1;
      if (sReqVal && sReqRdy) begin
        accCyc[acc] = c;
        acc++;
      end
      if (sRespVal && nResp < 4) begin
        respCyc[nResp] = c;
        respDat[nResp] = sRespData;
        nResp++;
      end
      @(negedge clk);
    end
    sReqVal = 1'b0;
    checkOutput("stream.accepts", 32'(acc), 32'd4);
    checkOutput("stream.responses", 32'(nResp), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < acc) checkOutput("stream.acceptCycle", 32'(accCyc[i]), 32'(2 * i));
      if (i < nResp) begin
        checkOutput("stream.respCycle", 32'(respCyc[i]), 32'(2 * i + 1));
        checkOutput("stream.respData", respDat[i], 32'h1000 + 32'(i));
      end
    end

    // Fill all storage through the backdoor so random reads are defined
    for (int i = 0; i < 256; i++) initWrite(8'(i), $urandom);

    // Randomized traffic against the memory model
    for (int n = 0; n < 60; n++) begin
      t    = 1'($urandom_range(0, 1));
      a    = $urandom;
      if (n % 3 == 0) a = {22'($urandom), 10'(n * 4 % 64)};
      d    = $urandom;
      poke = !t && ($urandom_range(0, 3) == 0);
      expD = t ? 32'd0 : refMem[wordIdx(a)];
      applyStimulus("rand", t, a, d, $urandom_range(0, 3), poke, $urandom, t, expD);
      if ($urandom_range(0, 4) == 0) initWrite(8'($urandom), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
